// File: rtl/sap_mar.sv
// ============================================================================
// Module   : sap_mar
// Purpose  : SAP-16 memory address register. It captures the low ADDR_W bits
//            of the system bus and drives the RAM address lines.
//            Optional feature macro MAR_INC_EN adds in-place increment.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sap_mar #(
    parameter int BUS_W  = 16,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mar_write,
    input  logic [BUS_W-1:0]  bus,
`ifdef MAR_INC_EN
    input  logic              mar_inc,
`endif
    output logic [ADDR_W-1:0] mar_out
);

    logic [ADDR_W-1:0] r_addr;

    if (ADDR_W < 1 || ADDR_W > BUS_W) begin : g_bad_width
        $error("sap_mar: ADDR_W must satisfy 1 <= ADDR_W <= BUS_W");
    end

    // The upper bus bits are deliberately discarded on load.
    if (ADDR_W < BUS_W) begin : g_trunc
        logic w_unused_upper;
        assign w_unused_upper = |bus[BUS_W-1:ADDR_W];
    end

    // rst > mar_write > mar_inc
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr <= '0;
        end else if (mar_write) begin
            r_addr <= bus[ADDR_W-1:0];
        end
`ifdef MAR_INC_EN
        else if (mar_inc) begin
            r_addr <= r_addr + ADDR_W'(1);
        end
`endif
    end

    assign mar_out = r_addr;

endmodule

`default_nettype wire

// File: tb/tb_sap_mar.sv
// ============================================================================
// Module   : tb_sap_mar
// Purpose  : Self-checking bench for sap_mar (vector table plus scoreboard).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sap_mar;

    logic        clk;
    logic        rst;
    logic        mar_write;
    logic [15:0] bus;
    logic [7:0]  mar_out;
`ifdef MAR_INC_EN
    logic        mar_inc;
`endif

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_q[$];

    typedef struct {
        logic        rst;
        logic        wr;
        logic        inc;
        logic [15:0] bus;
        logic [7:0]  exp;
        string       name;
    } vec_t;

    vec_t tbl[$];

    sap_mar #(
        .BUS_W  (16),
        .ADDR_W (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mar_write (mar_write),
        .bus       (bus),
`ifdef MAR_INC_EN
        .mar_inc   (mar_inc),
`endif
        .mar_out   (mar_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic expect_val(input logic [7:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string name);
        logic [7:0] e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL %s: scoreboard empty, actual=%h", name, mar_out);
        end else begin
            e = exp_q.pop_front();
            if (mar_out !== e) begin
                bad++;
                $display("FAIL %s: actual=%h expected=%h", name, mar_out, e);
            end
        end
    endtask

    // Drive one vector at the falling edge, then sample just after the rising edge.
    task automatic apply(input vec_t v);
        @(negedge clk);
        rst       = v.rst;
        mar_write = v.wr;
        bus       = v.bus;
`ifdef MAR_INC_EN
        mar_inc   = v.inc;
`endif
        expect_val(v.exp);
        @(posedge clk);
        #1;
        check(v.name);
    endtask

    initial begin
        rst       = 1'b0;
        mar_write = 1'b0;
        bus       = 16'h0000;
`ifdef MAR_INC_EN
        mar_inc   = 1'b0;
`endif

        tbl.push_back('{1'b0, 1'b1, 1'b0, 16'hAB12, 8'h12, "trunc_load"});
        tbl.push_back('{1'b0, 1'b0, 1'b0, 16'hFFFF, 8'h12, "trunc_hold1"});
        tbl.push_back('{1'b0, 1'b0, 1'b0, 16'hFFFF, 8'h12, "trunc_hold2"});
        tbl.push_back('{1'b0, 1'b0, 1'b0, 16'hFFFF, 8'h12, "trunc_hold3"});
        tbl.push_back('{1'b1, 1'b1, 1'b0, 16'h0055, 8'h00, "rst_beats_load"});
        tbl.push_back('{1'b0, 1'b0, 1'b0, 16'h0077, 8'h00, "post_rst_hold"});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 16'h00C3, 8'hC3, "load_c3"});
        tbl.push_back('{1'b0, 1'b1, 1'b0, 16'h0001, 8'h01, "reload_01"});
`ifdef MAR_INC_EN
        tbl.push_back('{1'b0, 1'b1, 1'b0, 16'h00FE, 8'hFE, "inc_load_fe"});
        tbl.push_back('{1'b0, 1'b0, 1'b1, 16'h0000, 8'hFF, "inc_to_ff"});
        tbl.push_back('{1'b0, 1'b0, 1'b1, 16'h0000, 8'h00, "inc_wrap"});
        tbl.push_back('{1'b0, 1'b1, 1'b1, 16'h0010, 8'h10, "load_over_inc"});
        tbl.push_back('{1'b0, 1'b0, 1'b1, 16'hFFFF, 8'h11, "inc_after_load"});
`endif
        tbl.push_back('{1'b0, 1'b1, 1'b0, 16'h0080, 8'h80, "hold_load_80"});

        // Reset window 12..20 ns, then a timed load at the 25 ns edge.
        #12 rst = 1'b1;
        expect_val(8'h00);
        #1  check("rst_assert");
        expect_val(8'h00);
        #6  check("rst_hold");
        #1  rst = 1'b0;
        #1  bus = 16'h004A;
        #2  mar_write = 1'b1;
        expect_val(8'h4A);
        #3  check("basic_load");
        #2  mar_write = 1'b0;
        expect_val(8'h4A);
        #72 check("basic_hold_100ns");

        foreach (tbl[i]) apply(tbl[i]);

        // Hold 0x80 across random bus traffic, including an undriven bus.
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            mar_write = 1'b0;
            bus       = 16'($urandom);
            expect_val(8'h80);
            @(posedge clk);
            #1 check("hold_random");
        end
        @(negedge clk);
        bus = 16'hxxxx;
        expect_val(8'h80);
        @(posedge clk);
        #1 check("hold_bus_x");

        // Asynchronous reset between edges, with a load attempted under reset.
        @(negedge clk);
        bus       = 16'h004A;
        mar_write = 1'b1;
        expect_val(8'h4A);
        @(posedge clk);
        #1 check("mid_load_4a");
        #2 mar_write = 1'b0;
        rst = 1'b1;
        expect_val(8'h00);
        #1 check("mid_async_rst");
        bus       = 16'h0033;
        mar_write = 1'b1;
        expect_val(8'h00);
        @(posedge clk);
        #1 check("load_under_rst");
        @(negedge clk);
        rst = 1'b0;
        expect_val(8'h33);
        @(posedge clk);
        #1 check("load_at_release");
        mar_write = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
